fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded at reset.
REQ-002 Parameter NOP_INSTR, default 16'h0800, bubble encoding driven on instr_out when invalid.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 stall  input  1  hazard hold from decode; 1 = IF/ID contents must not change.
REQ-006 redirect  input  1  taken branch/jump from downstream; flush and refetch.
REQ-007 redirect_pc  input  16  target PC, sampled when redirect=1.
REQ-008 imem_ready  input  1  instruction memory returns imem_rdata this cycle.
REQ-009 imem_rdata  input  16  instruction word.
REQ-010 imem_err  input  1  memory fault, valid only with imem_ready=1.
REQ-011 imem_req  output  1  fetch request; addr held stable while req=1 and ready=0 (unless redirected).
REQ-012 imem_addr  output  16  current PC.
REQ-013 instr_out  output  16  IF/ID instruction to decode.
REQ-014 pc_plus2_out  output  16  IF/ID PC+2 of instr_out.
REQ-015 valid_out  output  1  IF/ID holds a real instruction.
REQ-016 halted  output  1  fetch stopped (state HALTED).
REQ-017 err  output  1  sticky memory fault flag.

Function
REQ-018 States: FETCH (imem_req=1), HOLD (imem_req=0, fetched word in skid buffer), HALTED (imem_req=0, PC frozen).
REQ-019 FETCH, imem_ready=1, imem_err=0, stall=0: IF/ID <= {imem_rdata, PC+2, valid=1}; PC <= PC+2; stay FETCH; one-cycle latency ready -> instr_out.
REQ-020 FETCH, imem_ready=1, stall=1: word and PC+2 into skid buffer; PC <= PC+2; go HOLD; IF/ID unchanged.
REQ-021 HOLD, stall=0: IF/ID <= skid contents, valid=1; go FETCH (or HALTED if skid word is HALT).
REQ-022 FETCH, imem_ready=0, stall=0: IF/ID <= bubble (instr_out=NOP_INSTR, valid_out=0); PC unchanged.
REQ-023 stall=1 with no fetched word to store: IF/ID and PC unchanged.
REQ-024 HALT = opcode bits[15:11]=5'b00000; when a HALT word is accepted (IF/ID or skid), PC still advances +2, then state HALTED after it reaches IF/ID.
REQ-025 HALTED: no requests; with stall=0, IF/ID loads bubbles after the HALT word is consumed.
REQ-026 redirect=1 overrides all: PC <= redirect_pc; IF/ID <= bubble; skid discarded; state FETCH (also exits HALTED); any same-cycle imem_rdata discarded; stall ignored that cycle.
REQ-027 imem_ready=1 with imem_err=1 (no redirect): word not loaded; err <= 1; state HALTED; err clears only by reset.
REQ-028 PC arithmetic 16-bit modulo: 16'hFFFE + 2 = 16'h0000; no error.
REQ-029 imem_addr = PC combinationally; imem_req = (state==FETCH) and rst deasserted.

Reset
REQ-030 While rst=0 (asynchronous): PC=RESET_PC, state FETCH, instr_out=NOP_INSTR, pc_plus2_out=0, valid_out=0, skid empty, err=0, halted=0, imem_req=0.
REQ-031 First request issues in the first cycle after rst deasserts, at imem_addr=RESET_PC.
REQ-032 Reset asserted mid-wait or mid-HOLD: all in-flight data dropped; imem_rdata ignored until the new FETCH.

Structure
REQ-033 Shared package fetch_pkg: state enum {FETCH, HOLD, HALTED}, HALT_OPCODE, NOP_INSTR, RESET_PC default.
REQ-034 One sub-module if_id_latch: 16-bit instr, 16-bit pc_plus2, valid; inputs load, flush; flush priority over load.

Verification
REQ-035 Reset release, imem_ready=1 each cycle, words 0x4001,0x4102: imem_addr 0x0000,0x0002; instr_out 0x4001 with pc_plus2_out 0x0002, next cycle 0x4102/0x0004.
REQ-036 stall=1 for 3 cycles while word 0x4203 returns: IF/ID holds prior word, state HOLD, imem_req=0; stall drop -> instr_out=0x4203 next cycle, no word lost or duplicated.
REQ-037 redirect=1, redirect_pc=0x0100 same cycle as stall=1 and imem_ready=1: valid_out=0, instr_out=0x0800, next imem_addr=0x0100.
REQ-038 Fetch 0x0000 (HALT) at PC 0x0010: instr_out=0x0000, halted=1, imem_req=0 thereafter; redirect to 0x0020 resumes fetch, halted=0.
REQ-039 imem_ready=1, imem_err=1 at PC 0x0006: err=1 sticky, halted=1, word not loaded; only rst=0 clears err.
REQ-040 PC=0xFFFE fetch accepted: pc_plus2_out=0x0000, next imem_addr=0x0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_HOLD,
        ST_HALTED
    } fetch_state_e;

    localparam logic [4:0]  HALT_OPCODE   = 5'b00000;
    localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;
    localparam logic [15:0] RESET_PC_DEF  = 16'h0000;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_plus2;
    } fetch_word_t;

    function automatic logic is_halt(input logic [15:0] word);
        return word[15:11] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline register; a flush (bubble) always wins over a load.
module if_id_latch
    import fetch_pkg::*;
#(
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic [15:0] instr_i,
    input  logic [15:0] pc_plus2_i,
    output logic [15:0] instr_o,
    output logic [15:0] pc_plus2_o,
    output logic        valid_o
);

    logic [15:0] instr_q;
    logic [15:0] pc_plus2_q;
    logic        valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q    <= NOP_INSTR;
            pc_plus2_q <= 16'h0000;
            valid_q    <= 1'b0;
        end else if (flush_i) begin
            instr_q    <= NOP_INSTR;
            pc_plus2_q <= 16'h0000;
            valid_q    <= 1'b0;
        end else if (load_i) begin
            instr_q    <= instr_i;
            pc_plus2_q <= pc_plus2_i;
            valid_q    <= 1'b1;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus2_o = pc_plus2_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, request FSM with a one-entry skid buffer for stalls,
// HALT / fault stop, and redirect flush feeding the IF/ID register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    input  logic        imem_err,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] instr_out,
    output logic [15:0] pc_plus2_out,
    output logic        valid_out,
    output logic        halted,
    output logic        err
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    fetch_word_t  skid_q, skid_d;
    logic         err_q, err_d;

    logic         ifid_load, ifid_flush;
    fetch_word_t  ifid_word;
    logic [15:0]  pc_inc;

    assign pc_inc = pc_q + 16'd2;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        skid_d     = skid_q;
        err_d      = err_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_word  = '{instr: imem_rdata, pc_plus2: pc_inc};

        if (redirect) begin
            // Redirect beats stall, skid contents and any returning word.
            pc_d       = redirect_pc;
            skid_d     = '0;
            ifid_flush = 1'b1;
            state_d    = ST_FETCH;
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (imem_ready && imem_err) begin
                        err_d      = 1'b1;
                        ifid_flush = !stall;
                        state_d    = ST_HALTED;
                    end else if (imem_ready && stall) begin
                        skid_d  = '{instr: imem_rdata, pc_plus2: pc_inc};
                        pc_d    = pc_inc;
                        state_d = ST_HOLD;
                    end else if (imem_ready) begin
                        ifid_load = 1'b1;
                        pc_d      = pc_inc;
                        state_d   = is_halt(imem_rdata) ? ST_HALTED : ST_FETCH;
                    end else if (!stall) begin
                        ifid_flush = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ifid_load = 1'b1;
                        ifid_word = skid_q;
                        state_d   = is_halt(skid_q.instr) ? ST_HALTED : ST_FETCH;
                    end
                end
                ST_HALTED: begin
                    ifid_flush = !stall;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            skid_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
            err_q   <= err_d;
        end
    end

    if_id_latch #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ifid_load),
        .flush_i    (ifid_flush),
        .instr_i    (ifid_word.instr),
        .pc_plus2_i (ifid_word.pc_plus2),
        .instr_o    (instr_out),
        .pc_plus2_o (pc_plus2_out),
        .valid_o    (valid_out)
    );

    assign imem_addr = pc_q;
    assign imem_req  = (state_q == ST_FETCH) && rst;
    assign halted    = (state_q == ST_HALTED);
    assign err       = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, stall/skid, bubbles,
// redirect, HALT, memory fault, PC wrap and reset during HOLD.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect, imem_ready, imem_err;
    logic [15:0] redirect_pc, imem_rdata;
    logic        imem_req, valid_out, halted, err;
    logic [15:0] imem_addr, instr_out, pc_plus2_out;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .imem_err     (imem_err),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .instr_out    (instr_out),
        .pc_plus2_out (pc_plus2_out),
        .valid_out    (valid_out),
        .halted       (halted),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; redirect = 0; redirect_pc = 16'h0000;
        imem_ready = 0; imem_rdata = 16'h0000; imem_err = 0;
    endtask

    task automatic do_redirect(input logic [15:0] target);
        redirect = 1; redirect_pc = target; imem_ready = 0; stall = 0;
        step();
        redirect = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        repeat (3) step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", imem_req); end
        checks++; if (instr_out !== 16'h0800) begin errors++; $display("FAIL reset_instr got %h exp 0800", instr_out); end
        checks++; if (pc_plus2_out !== 16'h0000) begin errors++; $display("FAIL reset_pc2 got %h exp 0000", pc_plus2_out); end
        checks++; if ({valid_out, halted, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {valid_out, halted, err}); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h exp 0000", imem_addr); end
        rst = 1;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %0b exp 1", imem_req); end
    endtask

    task automatic test_stream();
        imem_ready = 1; imem_rdata = 16'h4001;
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL stream_addr0 got %h exp 0000", imem_addr); end
        step();
        checks++; if ({instr_out, pc_plus2_out, valid_out} !== {16'h4001, 16'h0002, 1'b1}) begin errors++; $display("FAIL stream_w0 got %h/%h/%b exp 4001/0002/1", instr_out, pc_plus2_out, valid_out); end
        checks++; if (imem_addr !== 16'h0002) begin errors++; $display("FAIL stream_addr1 got %h exp 0002", imem_addr); end
        imem_rdata = 16'h4102;
        step();
        checks++; if ({instr_out, pc_plus2_out, valid_out} !== {16'h4102, 16'h0004, 1'b1}) begin errors++; $display("FAIL stream_w1 got %h/%h/%b exp 4102/0004/1", instr_out, pc_plus2_out, valid_out); end
        checks++; if (imem_addr !== 16'h0004) begin errors++; $display("FAIL stream_addr2 got %h exp 0004", imem_addr); end
    endtask

    task automatic test_stall();
        imem_ready = 1; imem_rdata = 16'h4203; stall = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            imem_ready = 0; imem_rdata = 16'hDEAD;
            checks++; if ({instr_out, pc_plus2_out} !== {16'h4102, 16'h0004}) begin errors++; $display("FAIL stall_hold%0d got %h/%h exp 4102/0004", c, instr_out, pc_plus2_out); end
            checks++; if ({imem_req, imem_addr} !== {1'b0, 16'h0006}) begin errors++; $display("FAIL stall_req%0d got %b/%h exp 0/0006", c, imem_req, imem_addr); end
        end
        stall = 0;
        step();
        checks++; if ({instr_out, pc_plus2_out, valid_out} !== {16'h4203, 16'h0006, 1'b1}) begin errors++; $display("FAIL skid_out got %h/%h/%b exp 4203/0006/1", instr_out, pc_plus2_out, valid_out); end
        checks++; if ({imem_req, imem_addr} !== {1'b1, 16'h0006}) begin errors++; $display("FAIL skid_resume got %b/%h exp 1/0006", imem_req, imem_addr); end
        imem_ready = 1; imem_rdata = 16'h4304;
        step();
        checks++; if ({instr_out, pc_plus2_out} !== {16'h4304, 16'h0008}) begin errors++; $display("FAIL after_skid got %h/%h exp 4304/0008", instr_out, pc_plus2_out); end
    endtask

    task automatic test_bubble();
        imem_ready = 0;
        step();
        checks++; if ({instr_out, valid_out} !== {16'h0800, 1'b0}) begin errors++; $display("FAIL bubble got %h/%b exp 0800/0", instr_out, valid_out); end
        checks++; if (imem_addr !== 16'h0008) begin errors++; $display("FAIL bubble_addr got %h exp 0008", imem_addr); end
    endtask

    task automatic test_redirect();
        redirect = 1; redirect_pc = 16'h0100; stall = 1; imem_ready = 1; imem_rdata = 16'h4505;
        step();
        redirect = 0; stall = 0; imem_ready = 0;
        checks++; if ({instr_out, valid_out} !== {16'h0800, 1'b0}) begin errors++; $display("FAIL redir_flush got %h/%b exp 0800/0", instr_out, valid_out); end
        checks++; if ({imem_req, imem_addr} !== {1'b1, 16'h0100}) begin errors++; $display("FAIL redir_addr got %b/%h exp 1/0100", imem_req, imem_addr); end
    endtask

    task automatic test_halt();
        do_redirect(16'h0010);
        imem_ready = 1; imem_rdata = 16'h0000;
        step();
        imem_ready = 0;
        checks++; if ({instr_out, pc_plus2_out, valid_out} !== {16'h0000, 16'h0012, 1'b1}) begin errors++; $display("FAIL halt_word got %h/%h/%b exp 0000/0012/1", instr_out, pc_plus2_out, valid_out); end
        checks++; if ({halted, imem_req, imem_addr} !== {1'b1, 1'b0, 16'h0012}) begin errors++; $display("FAIL halt_state got %b/%b/%h exp 1/0/0012", halted, imem_req, imem_addr); end
        step();
        checks++; if ({instr_out, valid_out, halted, imem_req} !== {16'h0800, 1'b0, 1'b1, 1'b0}) begin errors++; $display("FAIL halted_bubble got %h/%b/%b/%b exp 0800/0/1/0", instr_out, valid_out, halted, imem_req); end
        do_redirect(16'h0020);
        checks++; if ({halted, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0020}) begin errors++; $display("FAIL halt_exit got %b/%b/%h exp 0/1/0020", halted, imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        do_redirect(16'hFFFE);
        imem_ready = 1; imem_rdata = 16'h4606;
        step();
        imem_ready = 0;
        checks++; if ({instr_out, pc_plus2_out} !== {16'h4606, 16'h0000}) begin errors++; $display("FAIL wrap_pc2 got %h/%h exp 4606/0000", instr_out, pc_plus2_out); end
        checks++; if ({imem_addr, err} !== {16'h0000, 1'b0}) begin errors++; $display("FAIL wrap_addr got %h/%b exp 0000/0", imem_addr, err); end
    endtask

    task automatic test_err();
        do_redirect(16'h0006);
        imem_ready = 1; imem_err = 1; imem_rdata = 16'h4707;
        step();
        imem_ready = 0; imem_err = 0;
        checks++; if ({err, halted, imem_req} !== 3'b110) begin errors++; $display("FAIL err_state got %b exp 110", {err, halted, imem_req}); end
        checks++; if ({instr_out, valid_out} !== {16'h0800, 1'b0}) begin errors++; $display("FAIL err_noload got %h/%b exp 0800/0", instr_out, valid_out); end
        checks++; if (imem_addr !== 16'h0006) begin errors++; $display("FAIL err_addr got %h exp 0006", imem_addr); end
        do_redirect(16'h0030);
        checks++; if ({err, halted} !== 2'b10) begin errors++; $display("FAIL err_sticky got %b exp 10", {err, halted}); end
        rst = 0;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err); end
        step();
        rst = 1;
    endtask

    task automatic test_reset_midhold();
        imem_ready = 1; imem_rdata = 16'h4808; stall = 1;
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL midhold_enter got %b exp 0", imem_req); end
        rst = 0;
        #1;
        checks++; if ({instr_out, valid_out, imem_req, imem_addr} !== {16'h0800, 1'b0, 1'b0, 16'h0000}) begin errors++; $display("FAIL midhold_rst got %h/%b/%b/%h exp 0800/0/0/0000", instr_out, valid_out, imem_req, imem_addr); end
        step();
        rst = 1; stall = 0; imem_ready = 0;
        step();
        checks++; if ({valid_out, instr_out, imem_req, imem_addr} !== {1'b0, 16'h0800, 1'b1, 16'h0000}) begin errors++; $display("FAIL midhold_drop got %b/%h/%b/%h exp 0/0800/1/0000", valid_out, instr_out, imem_req, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_bubble();
        test_redirect();
        test_halt();
        test_wrap();
        test_err();
        test_reset_midhold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
